// File: rtl/ball_frame_render_pkg.sv
// Shared types and constants for the ball frame renderer: FSM states, LCD opcodes, pixel type.
package ball_frame_render_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        PIX_HI,
        PIX_LO,
        DONE
    } state_t;

    localparam logic [7:0] CASET = 8'h2A;
    localparam logic [7:0] RASET = 8'h2B;
    localparam logic [7:0] RAMWR = 8'h2C;

    localparam int CMD_WORDS = 11;

    typedef logic [15:0] rgb565_t;

    // Window setup: full-screen column range, full-screen row range, then memory write.
    function automatic logic [8:0] cmd_word(input logic [3:0] idx,
                                            input logic [7:0] col_end,
                                            input logic [7:0] row_end);
        case (idx)
            4'd0:    cmd_word = {1'b0, CASET};
            4'd4:    cmd_word = {1'b1, col_end};
            4'd5:    cmd_word = {1'b0, RASET};
            4'd9:    cmd_word = {1'b1, row_end};
            4'd10:   cmd_word = {1'b0, RAMWR};
            default: cmd_word = {1'b1, 8'h00};
        endcase
    endfunction

endpackage

// File: rtl/ball_frame_render_mask.sv
// ball_mask_rom: 16x16 circular ball mask, one row per lookup; bit c set when pixel (row, c) is inside.
// Only built when BALL_ROUND_EN is defined; the square-ball build carries no mask logic at all.
`ifdef BALL_ROUND_EN
module ball_mask_rom
    import ball_frame_render_pkg::*;
(
    input  logic [3:0]  row,
    output logic [15:0] bits
);

    // Pixel centres sit at half-integer offsets, so compare (2c-15, 2r-15) against radius 16.
    function automatic logic [15:0] circle_row(input logic [3:0] r);
        int dx;
        int dy;
        circle_row = '0;
        dy = 2 * int'(r) - 15;
        for (int c = 0; c < 16; c++) begin
            dx = 2 * c - 15;
            circle_row[c] = (dx * dx + dy * dy <= 256);
        end
    endfunction

    assign bits = circle_row(row);

endmodule
`endif

// File: rtl/ball_frame_render.sv
// Streams one full RGB565 frame (window setup + pixels) to lcd_write, one word per en_write/wr_done handshake.
// Build option BALL_ROUND_EN: draw the ball through a circular mask instead of as a filled square.
module ball_frame_render
    import ball_frame_render_pkg::*;
#(
    parameter int          WIDTH      = 240,
    parameter int          HEIGHT     = 240,
    parameter int          BALL_SIZE  = 16,
    parameter int          BALL_X     = 112,
    parameter logic [15:0] BG_COLOR   = 16'hFFFF,
    parameter logic [15:0] BALL_COLOR = 16'hF800
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic [7:0] ball_y,
    input  logic       wr_done,
    output logic [8:0] lcd_data,
    output logic       en_write,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [15:0] X_LAST   = 16'(WIDTH - 1);
    localparam logic [15:0] Y_LAST   = 16'(HEIGHT - 1);
    localparam logic [15:0] BX_LO    = 16'(BALL_X);
    localparam logic [15:0] BX_HI    = 16'(BALL_X + BALL_SIZE);
    localparam logic [15:0] BS16     = 16'(BALL_SIZE);
    localparam logic [7:0]  LY_MAX   = 8'(HEIGHT - BALL_SIZE);
    localparam logic [7:0]  COL_END  = 8'(WIDTH - 1);
    localparam logic [7:0]  ROW_END  = 8'(HEIGHT - 1);
    localparam logic [3:0]  CMD_LAST = 4'(CMD_WORDS - 1);

    state_t      state;
    logic [3:0]  cmd_idx;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  ly;
    logic [7:0]  lo_byte;
    logic        pending;

    logic [15:0] nx;
    logic [15:0] ny;
    logic [15:0] tx;
    logic [15:0] ty;
    logic [15:0] ly16;
    logic        in_sq;
    logic        in_ball;
    logic        ack;
    logic        last_px;
    rgb565_t     pix;

    // Colour is always evaluated for the pixel whose high byte goes out next:
    // (x,y) while still in CMD, the following raster position while in PIX_LO.
    always_comb begin
        nx      = (x == X_LAST) ? 16'd0 : x + 16'd1;
        ny      = (x == X_LAST) ? y + 16'd1 : y;
        tx      = (state == PIX_LO) ? nx : x;
        ty      = (state == PIX_LO) ? ny : y;
        ly16    = {8'd0, ly};
        in_sq   = (tx >= BX_LO) && (tx < BX_HI) && (ty >= ly16) && (ty < ly16 + BS16);
        ack     = wr_done && pending;
        last_px = (x == X_LAST) && (y == Y_LAST);
    end

`ifdef BALL_ROUND_EN
    logic [3:0]  mask_r;
    logic [3:0]  mask_c;
    logic [15:0] mask_bits;

    assign mask_r = 4'(ty - ly16);
    assign mask_c = 4'(tx - BX_LO);

    ball_mask_rom u_mask (
        .row  (mask_r),
        .bits (mask_bits)
    );

    assign in_ball = in_sq && mask_bits[mask_c];
`else
    assign in_ball = in_sq;
`endif

    assign pix = in_ball ? BALL_COLOR : BG_COLOR;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cmd_idx    <= '0;
            x          <= '0;
            y          <= '0;
            ly         <= '0;
            lo_byte    <= '0;
            pending    <= 1'b0;
            lcd_data   <= 9'h000;
            en_write   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            en_write   <= 1'b0;
            frame_done <= 1'b0;
            if (ack) begin
                pending <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        ly       <= (ball_y > LY_MAX) ? LY_MAX : ball_y;
                        busy     <= 1'b1;
                        cmd_idx  <= '0;
                        x        <= '0;
                        y        <= '0;
                        lcd_data <= cmd_word(4'd0, COL_END, ROW_END);
                        en_write <= 1'b1;
                        pending  <= 1'b1;
                        state    <= CMD;
                    end
                end
                CMD: begin
                    if (ack) begin
                        en_write <= 1'b1;
                        pending  <= 1'b1;
                        if (cmd_idx == CMD_LAST) begin
                            lcd_data <= {1'b1, pix[15:8]};
                            lo_byte  <= pix[7:0];
                            state    <= PIX_HI;
                        end else begin
                            cmd_idx  <= cmd_idx + 4'd1;
                            lcd_data <= cmd_word(cmd_idx + 4'd1, COL_END, ROW_END);
                        end
                    end
                end
                PIX_HI: begin
                    if (ack) begin
                        lcd_data <= {1'b1, lo_byte};
                        en_write <= 1'b1;
                        pending  <= 1'b1;
                        state    <= PIX_LO;
                    end
                end
                PIX_LO: begin
                    if (ack) begin
                        if (last_px) begin
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            x        <= nx;
                            y        <= ny;
                            lcd_data <= {1'b1, pix[15:8]};
                            lo_byte  <= pix[7:0];
                            en_write <= 1'b1;
                            pending  <= 1'b1;
                            state    <= PIX_HI;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
